button_press_decoder: RTL and testbench



---
 rtl/button_pkg.sv | 26 ++
 rtl/button_press_decoder_if.sv | 26 ++
 rtl/level_edge_detect.sv | 26 ++
 rtl/button_press_decoder.sv | 154 +++++++++++++++
 tb/tb_button_press_decoder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/button_pkg.sv
// Shared types and default timing for the button input chain (conditioner and
// press decoder). Counts are in clk samples.
package button_pkg;

  typedef enum logic [2:0] {IDLE, HELD1, GAP, HELD2, LONG} press_state_t;

  localparam int unsigned LONG_COUNT_DEF   = 25_000_000;
  localparam int unsigned DOUBLE_GAP_DEF   = 12_500_000;
  localparam int unsigned REPEAT_COUNT_DEF = 5_000_000;

  typedef struct packed {
    logic press;
    logic release_pulse;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_pulse;
  } btn_evt_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_press_decoder_if.sv
// Level-in / events-out bundle between a button conditioner (master) and the
// press decoder (slave). "release" is a language keyword, hence release_pulse.
interface button_press_decoder_if;

  logic btn;
  logic press;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn,
    input  press, release_pulse, short_press, long_press,
           double_click, repeat_pulse, held
  );

  modport slave (
    input  btn,
    output press, release_pulse, short_press, long_press,
           double_click, repeat_pulse, held
  );

endinterface

// File: rtl/level_edge_detect.sv
// One-sample delay of a clean level with combinational rise/fall strobes
// against the delayed copy.
module level_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall,
  output logic level_d
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise    = level & ~level_q;
  assign fall    = ~level & level_q;
  assign level_d = level_q;

endmodule

// File: rtl/button_press_decoder.sv
// Turns a debounced button level into registered one-cycle gesture events:
// press, release, short press, long press, double click and auto-repeat.
module button_press_decoder
  import button_pkg::*;
#(
  parameter int unsigned LONG_COUNT   = LONG_COUNT_DEF,
  parameter int unsigned DOUBLE_GAP   = DOUBLE_GAP_DEF,
  parameter int unsigned REPEAT_COUNT = REPEAT_COUNT_DEF
) (
  input logic                   clk,
  input logic                   reset,
  button_press_decoder_if.slave bus
);

  localparam int unsigned CNT_MAX = max3(LONG_COUNT, DOUBLE_GAP, REPEAT_COUNT);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  // The release sample is the first low sample of the gap, so the window closes
  // one count early; with a one-sample gap it closes on the first GAP sample.
  localparam int unsigned GAP_LAST_INT = (DOUBLE_GAP > 1) ? DOUBLE_GAP - 1 : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_INT);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_COUNT - 1);

  logic btn_rise;
  logic btn_fall;
  logic btn_level_d;

  press_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  btn_evt_t         evt_q, evt_d;

  level_edge_detect u_edge (
    .clk     (clk),
    .reset   (reset),
    .level   (bus.btn),
    .rise    (btn_rise),
    .fall    (btn_fall),
    .level_d (btn_level_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  // HELD1, HELD2 and LONG are only entered with the button high, so a fall is
  // the only way a low sample can show up in them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (btn_rise) begin
          state_d = HELD1;
          cnt_d   = CNT_ONE;
        end
      end
      HELD1: begin
        if (btn_fall) begin
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP: begin
        if (bus.btn) begin
          state_d = HELD2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD2: begin
        if (btn_fall) begin
          state_d = IDLE;
        end
      end
      LONG: begin
        if (btn_fall) begin
          state_d = IDLE;
        end else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    evt_d = '0;
    case (state_q)
      IDLE: begin
        evt_d.press = btn_rise;
      end
      HELD1: begin
        if (btn_fall) begin
          evt_d.release_pulse = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          evt_d.long_press = 1'b1;
        end
      end
      GAP: begin
        if (bus.btn) begin
          evt_d.press        = 1'b1;
          evt_d.double_click = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          evt_d.short_press = 1'b1;
        end
      end
      HELD2: begin
        evt_d.release_pulse = btn_fall;
      end
      LONG: begin
        if (btn_fall) begin
          evt_d.release_pulse = 1'b1;
        end else if (cnt_q == REP_LAST) begin
          evt_d.repeat_pulse = 1'b1;
        end
      end
      default: begin
        evt_d = '0;
      end
    endcase
  end

  assign bus.press         = evt_q.press;
  assign bus.release_pulse = evt_q.release_pulse;
  assign bus.short_press   = evt_q.short_press;
  assign bus.long_press    = evt_q.long_press;
  assign bus.double_click  = evt_q.double_click;
  assign bus.repeat_pulse  = evt_q.repeat_pulse;
  assign bus.held          = btn_level_d;

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed gesture scenarios for button_press_decoder with LONG=8, GAP=4,
// REPEAT=3; every sample's output vector is compared against a hand table.
module tb_button_press_decoder;

  localparam logic [6:0] EV_P  = 7'b100_0000;
  localparam logic [6:0] EV_R  = 7'b010_0000;
  localparam logic [6:0] EV_S  = 7'b001_0000;
  localparam logic [6:0] EV_L  = 7'b000_1000;
  localparam logic [6:0] EV_D  = 7'b000_0100;
  localparam logic [6:0] EV_RP = 7'b000_0010;
  localparam logic [6:0] EV_H  = 7'b000_0001;
  localparam int         MAXV  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  logic       btn_v [MAXV];
  logic       rst_v [MAXV];
  logic [6:0] exp_v [MAXV];
  int         vec_len;

  always #5 clk = ~clk;

  button_press_decoder_if bus ();

  button_press_decoder #(
    .LONG_COUNT   (8),
    .DOUBLE_GAP   (4),
    .REPEAT_COUNT (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.press, bus.release_pulse, bus.short_press, bus.long_press,
                bus.double_click, bus.repeat_pulse, bus.held};

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (P R S L D RP H)", tag, got, want);
    end
  endtask

  task automatic new_vec(input int len);
    vec_len = len;
    for (int i = 0; i < MAXV; i++) begin
      btn_v[i] = 1'b0;
      rst_v[i] = 1'b0;
      exp_v[i] = '0;
    end
  endtask

  task automatic hold(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      btn_v[i] = 1'b1;
      exp_v[i] = exp_v[i] | EV_H;
    end
  endtask

  task automatic ev(input int e, input logic [6:0] m);
    exp_v[e] = exp_v[e] | m;
  endtask

  task automatic rst_at(input int e);
    rst_v[e] = 1'b1;
    exp_v[e] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    bus.btn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("reset[%0d]", i), obs, 7'b0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic play(input string tag);
    int err0;
    err0 = n_errors;
    do_reset();
    for (int i = 0; i < vec_len; i++) begin
      @(negedge clk);
      bus.btn = btn_v[i];
      reset   = rst_v[i];
      @(posedge clk);
      #1;
      check_val($sformatf("%s[E%0d]", tag, i), obs, exp_v[i]);
    end
    @(negedge clk);
    bus.btn = 1'b0;
    reset   = 1'b0;
    $display("scenario %-14s %0d samples, %0d new errors", tag, vec_len, n_errors - err0);
  endtask

  initial begin
    bus.btn = 1'b0;

    new_vec(12);
    hold(0, 2);
    ev(0, EV_P); ev(3, EV_R); ev(6, EV_S);
    play("short");

    new_vec(20);
    hold(0, 16);
    ev(0, EV_P); ev(7, EV_L); ev(10, EV_RP); ev(13, EV_RP); ev(16, EV_RP); ev(17, EV_R);
    play("long_repeat");

    new_vec(14);
    hold(0, 6);
    ev(0, EV_P); ev(7, EV_R); ev(10, EV_S);
    play("long_minus1");

    new_vec(12);
    hold(0, 7);
    ev(0, EV_P); ev(7, EV_L); ev(8, EV_R);
    play("long_exact");

    new_vec(30);
    hold(0, 1); hold(4, 24);
    ev(0, EV_P); ev(2, EV_R); ev(4, EV_P | EV_D); ev(25, EV_R);
    play("double");

    new_vec(14);
    hold(0, 1); hold(6, 7);
    ev(0, EV_P); ev(2, EV_R); ev(5, EV_S); ev(6, EV_P); ev(8, EV_R); ev(11, EV_S);
    play("gap_boundary");

    new_vec(24);
    hold(0, 20);
    ev(0, EV_P); ev(7, EV_L);
    rst_at(9); rst_at(10);
    ev(11, EV_P); ev(18, EV_L); ev(21, EV_R);
    play("reset_in_long");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
